// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the decode stage:
// controller states, RV32I major opcodes and common field widths.
package pipe_ctrl_pkg;

    localparam int OPCODE_W = 7;
    localparam int REG_W    = 5;
    localparam int FCNT_W   = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;
    localparam logic [OPCODE_W-1:0] OP     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] JALR   = 7'b1100111;
    localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;
    localparam logic [OPCODE_W-1:0] LUI    = 7'b0110111;
    localparam logic [OPCODE_W-1:0] AUIPC  = 7'b0010111;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: decodes which source registers the ID
// instruction reads and compares them against a load's destination in EX.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_NUM_WIDTH = REG_W
) (
    input  logic [OPCODE_W-1:0]      id_opcode,
    input  logic [REG_NUM_WIDTH-1:0] id_rs1,
    input  logic [REG_NUM_WIDTH-1:0] id_rs2,
    input  logic [OPCODE_W-1:0]      ex_opcode,
    input  logic [REG_NUM_WIDTH-1:0] ex_rd,
    output logic                     rs1_used,
    output logic                     rs2_used,
    output logic                     load_use
);

    assign rs1_used = id_opcode inside {OP, OP_IMM, LOAD, STORE, BRANCH, JALR};
    assign rs2_used = id_opcode inside {OP, STORE, BRANCH};

    // x0 is never a real dependency, so a load to x0 cannot stall anything
    assign load_use = (ex_opcode == LOAD) && (ex_rd != '0) &&
                      ((rs1_used && (ex_rd == id_rs1)) ||
                       (rs2_used && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/bubble/flush controller for the in-order pipe: load-use bubbles,
// multi-cycle flush after redirects, memory-busy freeze, stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_NUM_WIDTH = REG_W,
    parameter int FLUSH_CYCLES  = 2,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [OPCODE_W-1:0]      id_opcode,
    input  logic [REG_NUM_WIDTH-1:0] id_rs1,
    input  logic [REG_NUM_WIDTH-1:0] id_rs2,
    input  logic [OPCODE_W-1:0]      ex_opcode,
    input  logic [REG_NUM_WIDTH-1:0] ex_rd,
    input  logic                     ex_redirect,
    input  logic                     mem_busy,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     stall_ex,
    output logic                     bubble_ex,
    output logic                     flush,
    output logic [1:0]               ctrl_state,
    output logic [CNT_WIDTH-1:0]     stall_count
);

    localparam logic [FCNT_W-1:0] FCNT_FULL   = FCNT_W'(FLUSH_CYCLES);
    localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
    localparam ctrl_state_e       REDIR_NEXT  = (FLUSH_CYCLES > 1) ? FLUSH : RUN;

    ctrl_state_e       state, state_nxt;
    logic [FCNT_W-1:0] fcnt, fcnt_nxt;
    logic              pending, pending_nxt;
    logic              hold_front, hold_ex, bub, fl;
    logic              rs1_used, rs2_used, load_use;
    logic              unused_uses;

    hazard_detect #(.REG_NUM_WIDTH(REG_NUM_WIDTH)) u_detect (
        .id_opcode (id_opcode),
        .id_rs1    (id_rs1),
        .id_rs2    (id_rs2),
        .ex_opcode (ex_opcode),
        .ex_rd     (ex_rd),
        .rs1_used  (rs1_used),
        .rs2_used  (rs2_used),
        .load_use  (load_use)
    );

    assign unused_uses = rs1_used ^ rs2_used;

    always_comb begin
        state_nxt   = state;
        fcnt_nxt    = fcnt;
        pending_nxt = pending;
        hold_front  = 1'b0;
        hold_ex     = 1'b0;
        bub         = 1'b0;
        fl          = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    hold_front  = 1'b1;
                    hold_ex     = 1'b1;
                    pending_nxt = ex_redirect;
                    state_nxt   = MEM_WAIT;
                end else if (ex_redirect) begin
                    fl        = 1'b1;
                    fcnt_nxt  = FCNT_RELOAD;
                    state_nxt = REDIR_NEXT;
                end else if (load_use) begin
                    hold_front = 1'b1;
                    bub        = 1'b1;
                end
            end
            FLUSH: begin
                // A freeze mid-flush restarts the whole flush once memory is free
                if (mem_busy) begin
                    hold_front  = 1'b1;
                    hold_ex     = 1'b1;
                    pending_nxt = 1'b1;
                    fcnt_nxt    = '0;
                    state_nxt   = MEM_WAIT;
                end else begin
                    fl = 1'b1;
                    if (ex_redirect) begin
                        fcnt_nxt  = FCNT_RELOAD;
                        state_nxt = REDIR_NEXT;
                    end else begin
                        fcnt_nxt = (fcnt != '0) ? fcnt - 1'b1 : '0;
                        if (fcnt <= FCNT_W'(1)) state_nxt = RUN;
                    end
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    hold_front = 1'b1;
                    hold_ex    = 1'b1;
                    if (ex_redirect) pending_nxt = 1'b1;
                end else begin
                    pending_nxt = 1'b0;
                    if (pending || ex_redirect) begin
                        fcnt_nxt  = FCNT_FULL;
                        state_nxt = FLUSH;
                    end else begin
                        state_nxt = RUN;
                    end
                end
            end
            default: begin
                state_nxt   = RUN;
                fcnt_nxt    = '0;
                pending_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            fcnt    <= '0;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            fcnt    <= fcnt_nxt;
            pending <= pending_nxt;
        end
    end

    // Gate with reset so the pipe sees no control activity while held in reset
    assign stall_if   = reset & hold_front;
    assign stall_id   = reset & hold_front;
    assign stall_ex   = reset & hold_ex;
    assign bubble_ex  = reset & bub;
    assign flush      = reset & fl;
    assign ctrl_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_count <= '0;
        else if (stall_if && (stall_count != '1))
            stall_count <= stall_count + 1'b1;
    end

endmodule
